// File: rtl/idex_if.sv
// ID/EX pipeline boundary bundle: decoded instruction in, registered EX contents out.
// master = decode/hazard side driving id_*, slave = the ID/EX register stage.
interface idex_if #(
   parameter int XLEN = 32
);
   logic            id_valid;
   logic [4:0]      id_rs1;
   logic [4:0]      id_rs2;
   logic [4:0]      id_rd;
   logic            id_uses_rs1;
   logic            id_uses_rs2;
   logic [XLEN-1:0] id_rs1_data;
   logic [XLEN-1:0] id_rs2_data;
   logic [XLEN-1:0] id_imm;
   logic [XLEN-1:0] id_pc;
   logic            id_regwrite;
   logic            id_memread;
   logic            id_memwrite;
   logic            id_memtoreg;
   logic            id_alusrc;
   logic [3:0]      id_aluop;
   logic            ex_flush;
   logic            stall_if_id;
   logic            ex_valid;
   logic [4:0]      ex_rs1;
   logic [4:0]      ex_rs2;
   logic [4:0]      ex_rd;
   logic [XLEN-1:0] ex_rs1_data;
   logic [XLEN-1:0] ex_rs2_data;
   logic [XLEN-1:0] ex_imm;
   logic [XLEN-1:0] ex_pc;
   logic            ex_regwrite;
   logic            ex_memread;
   logic            ex_memwrite;
   logic            ex_memtoreg;
   logic            ex_alusrc;
   logic [3:0]      ex_aluop;

   modport master (
      output id_valid, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
             id_rs1_data, id_rs2_data, id_imm, id_pc, id_regwrite, id_memread,
             id_memwrite, id_memtoreg, id_alusrc, id_aluop, ex_flush,
      input  stall_if_id, ex_valid, ex_rs1, ex_rs2, ex_rd, ex_rs1_data,
             ex_rs2_data, ex_imm, ex_pc, ex_regwrite, ex_memread, ex_memwrite,
             ex_memtoreg, ex_alusrc, ex_aluop
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
             id_rs1_data, id_rs2_data, id_imm, id_pc, id_regwrite, id_memread,
             id_memwrite, id_memtoreg, id_alusrc, id_aluop, ex_flush,
      output stall_if_id, ex_valid, ex_rs1, ex_rs2, ex_rd, ex_rs1_data,
             ex_rs2_data, ex_imm, ex_pc, ex_regwrite, ex_memread, ex_memwrite,
             ex_memtoreg, ex_alusrc, ex_aluop
   );
endinterface

// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use stall detection and flush/hazard bubble insertion.
// Optional IDEX_PERF_CNT_EN adds stall_count/flush_count bubble counters.
module idex_stage #(
   parameter int XLEN = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   idex_if.slave       bus
`ifdef IDEX_PERF_CNT_EN
   ,
   output logic [31:0] stall_count,
   output logic [31:0] flush_count
`endif
);

   typedef struct packed {
      logic            valid;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] pc;
      logic            regwrite;
      logic            memread;
      logic            memwrite;
      logic            memtoreg;
      logic            alusrc;
      logic [3:0]      aluop;
   } ex_reg_t;

   ex_reg_t ex_q, ex_d;
   logic    load_use;
   logic    take_id;

   // A load in EX cannot forward its data to the instruction now in ID.
   assign load_use = ex_q.valid & ex_q.memread & (ex_q.rd != 5'd0) & bus.id_valid &
                     ((bus.id_uses_rs1 & (bus.id_rs1 == ex_q.rd)) |
                      (bus.id_uses_rs2 & (bus.id_rs2 == ex_q.rd)));

   // Upstream is redirected on a flush, so holding IF/ID would be pointless.
   assign bus.stall_if_id = load_use & ~bus.ex_flush;
   assign take_id         = bus.id_valid & ~bus.ex_flush & ~load_use;

   // NOTE: ex_d defaults to the all-zero bubble so every path assigns it and no latch is inferred.
   always_comb begin
      ex_d = '0;
      if (take_id) begin
         ex_d.valid    = 1'b1;
         ex_d.rs1      = bus.id_rs1;
         ex_d.rs2      = bus.id_rs2;
         ex_d.rd       = bus.id_rd;
         ex_d.rs1_data = bus.id_rs1_data;
         ex_d.rs2_data = bus.id_rs2_data;
         ex_d.imm      = bus.id_imm;
         ex_d.pc       = bus.id_pc;
         ex_d.regwrite = bus.id_regwrite;
         ex_d.memread  = bus.id_memread;
         ex_d.memwrite = bus.id_memwrite;
         ex_d.memtoreg = bus.id_memtoreg;
         ex_d.alusrc   = bus.id_alusrc;
         ex_d.aluop    = bus.id_aluop;
      end
   end

   // NOTE: non-blocking assignments keep every flop sampling pre-edge values; data fields
   // are reset as well because the bubble state must read all-zero, not merely invalid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ex_q <= '0;
      else        ex_q <= ex_d;
   end

   assign bus.ex_valid    = ex_q.valid;
   assign bus.ex_rs1      = ex_q.rs1;
   assign bus.ex_rs2      = ex_q.rs2;
   assign bus.ex_rd       = ex_q.rd;
   assign bus.ex_rs1_data = ex_q.rs1_data;
   assign bus.ex_rs2_data = ex_q.rs2_data;
   assign bus.ex_imm      = ex_q.imm;
   assign bus.ex_pc       = ex_q.pc;
   assign bus.ex_regwrite = ex_q.regwrite;
   assign bus.ex_memread  = ex_q.memread;
   assign bus.ex_memwrite = ex_q.memwrite;
   assign bus.ex_memtoreg = ex_q.memtoreg;
   assign bus.ex_alusrc   = ex_q.alusrc;
   assign bus.ex_aluop    = ex_q.aluop;

`ifdef IDEX_PERF_CNT_EN
   logic [31:0] stall_count_q, flush_count_q;

   // Counters wrap naturally through 32-bit overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count_q <= '0;
         flush_count_q <= '0;
      end else begin
         if (bus.ex_flush)  flush_count_q <= flush_count_q + 32'd1;
         else if (load_use) stall_count_q <= stall_count_q + 32'd1;
      end
   end

   assign stall_count = stall_count_q;
   assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_idex_stage.sv
// Self-checking bench for idex_stage: directed hazard/flush/reset scenarios plus
// randomized traffic against an instruction-level reference model.
module tb_idex_stage;
   localparam int XLEN = 32;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   idex_if #(.XLEN(XLEN)) bus ();

`ifdef IDEX_PERF_CNT_EN
   logic [31:0] stall_count, flush_count;
   idex_stage #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus),
                                  .stall_count(stall_count), .flush_count(flush_count));
`else
   idex_stage #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

   typedef struct packed {
      logic        valid;
      logic [4:0]  rs1, rs2, rd;
      logic        uses1, uses2;
      logic [31:0] d1, d2, imm, pc;
      logic        rw, mr, mw, mtr, as;
      logic [3:0]  op;
      logic        flush;
   } instr_t;

   // What the EX stage is expected to hold: either nothing (bubble) or one instruction.
   typedef struct packed {
      logic        valid;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] d1, d2, imm, pc;
      logic        rw, mr, mw, mtr, as;
      logic [3:0]  op;
   } slot_t;

   instr_t      cur;
   slot_t       ex_m;
   int unsigned n_vec = 0;
   int unsigned n_bad = 0;
   int unsigned m_stalls = 0;
   int unsigned m_flushes = 0;
   logic        seen_stall;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic model_stall(input slot_t ex, input instr_t id);
      logic dep;
      dep = (id.uses1 && id.rs1 == ex.rd) || (id.uses2 && id.rs2 == ex.rd);
      return ex.valid && ex.mr && ex.rd != 0 && id.valid && dep && !id.flush;
   endfunction

   task automatic drive(input instr_t x);
      cur = x;
      bus.id_valid    = x.valid;
      bus.id_rs1      = x.rs1;
      bus.id_rs2      = x.rs2;
      bus.id_rd       = x.rd;
      bus.id_uses_rs1 = x.uses1;
      bus.id_uses_rs2 = x.uses2;
      bus.id_rs1_data = x.d1;
      bus.id_rs2_data = x.d2;
      bus.id_imm      = x.imm;
      bus.id_pc       = x.pc;
      bus.id_regwrite = x.rw;
      bus.id_memread  = x.mr;
      bus.id_memwrite = x.mw;
      bus.id_memtoreg = x.mtr;
      bus.id_alusrc   = x.as;
      bus.id_aluop    = x.op;
      bus.ex_flush    = x.flush;
   endtask

   task automatic check_ex(input string tag);
      check({tag, "_ctrl"},
            {103'd0, bus.ex_valid, bus.ex_rs1, bus.ex_rs2, bus.ex_rd, bus.ex_regwrite,
             bus.ex_memread, bus.ex_memwrite, bus.ex_memtoreg, bus.ex_alusrc, bus.ex_aluop},
            {103'd0, ex_m.valid, ex_m.rs1, ex_m.rs2, ex_m.rd, ex_m.rw, ex_m.mr, ex_m.mw,
             ex_m.mtr, ex_m.as, ex_m.op});
      check({tag, "_data"}, {bus.ex_rs1_data, bus.ex_rs2_data, bus.ex_imm, bus.ex_pc},
            {ex_m.d1, ex_m.d2, ex_m.imm, ex_m.pc});
`ifdef IDEX_PERF_CNT_EN
      check({tag, "_scnt"}, {96'd0, stall_count}, {96'd0, 32'(m_stalls)});
      check({tag, "_fcnt"}, {96'd0, flush_count}, {96'd0, 32'(m_flushes)});
`endif
   endtask

   // One pipeline cycle: present x, check the stall request, then check EX after the edge.
   task automatic cycle(input instr_t x, input string tag);
      logic exp_stall;
      @(negedge clk);
      drive(x);
      #1;
      exp_stall  = model_stall(ex_m, cur);
      seen_stall = bus.stall_if_id;
      check({tag, "_stall"}, {127'd0, seen_stall}, {127'd0, exp_stall});
      @(posedge clk);
      if (cur.flush) begin
         m_flushes++;
         ex_m = '0;
      end else if (exp_stall) begin
         m_stalls++;
         ex_m = '0;
      end else if (!cur.valid) begin
         ex_m = '0;
      end else begin
         ex_m = '{valid: 1'b1, rs1: cur.rs1, rs2: cur.rs2, rd: cur.rd, d1: cur.d1, d2: cur.d2,
                  imm: cur.imm, pc: cur.pc, rw: cur.rw, mr: cur.mr, mw: cur.mw, mtr: cur.mtr,
                  as: cur.as, op: cur.op};
      end
      #1;
      check_ex(tag);
   endtask

   function automatic instr_t mk(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                                 input logic mr, input logic flush);
      instr_t x;
      x       = '0;
      x.valid = 1'b1;
      x.rd    = rd;
      x.rs1   = rs1;
      x.uses1 = u1;
      x.rw    = 1'b1;
      x.mr    = mr;
      x.mtr   = mr;
      x.d1    = 32'h1000 + 32'(rd);
      x.pc    = 32'h400 + 32'(rd) * 4;
      x.flush = flush;
      return x;
   endfunction

   instr_t rnd;

   initial begin
      rst_n = 1'b0;
      ex_m  = '0;
      drive(mk(5'd3, 5'd1, 1'b1, 1'b0, 1'b0));
      #3;
      check("rst_ex_valid", {127'd0, bus.ex_valid}, 128'd0);
      check_ex("rst");
      @(posedge clk);
      #1;
      check("rst_hold_stall", {127'd0, bus.stall_if_id}, 128'd0);
      check_ex("rst_hold");
      @(negedge clk);
      rst_n = 1'b1;

      // Plain capture: rd=5, rs1_data=0x11, aluop=3.
      rnd = mk(5'd5, 5'd2, 1'b1, 1'b0, 1'b0);
      rnd.d1 = 32'h11;
      rnd.op = 4'd3;
      cycle(rnd, "normal");
      check("normal_rd", {123'd0, bus.ex_rd}, 128'd5);
      check("normal_aluop", {124'd0, bus.ex_aluop}, 128'd3);
      check("normal_rs1d", {96'd0, bus.ex_rs1_data}, 128'h11);

      // Load-use on x7: one stall, bubble, then the add enters EX.
      cycle(mk(5'd7, 5'd0, 1'b0, 1'b1, 1'b0), "lw7");
      cycle(mk(5'd9, 5'd7, 1'b1, 1'b0, 1'b0), "lu_stall");
      check("lu_stall_req", {127'd0, seen_stall}, 128'd1);
      check("lu_bubble", {126'd0, bus.ex_valid, bus.ex_memread}, 128'd0);
      cycle(mk(5'd9, 5'd7, 1'b1, 1'b0, 1'b0), "lu_go");
      check("lu_go_req", {127'd0, seen_stall}, 128'd0);
      check("lu_go_rs1", {122'd0, bus.ex_valid, bus.ex_rs1}, {122'd0, 1'b1, 5'd7});

      // Load to x0 never stalls.
      cycle(mk(5'd0, 5'd0, 1'b0, 1'b1, 1'b0), "lw0");
      cycle(mk(5'd4, 5'd0, 1'b1, 1'b0, 1'b0), "x0_use");
      check("x0_use_req", {127'd0, seen_stall}, 128'd0);
      check("x0_use_valid", {127'd0, bus.ex_valid}, 128'd1);

      // Flush and hazard together: flush wins, no stall request, no later stall.
      cycle(mk(5'd7, 5'd0, 1'b0, 1'b1, 1'b0), "lw7b");
      cycle(mk(5'd9, 5'd7, 1'b1, 1'b0, 1'b1), "fl_hz");
      check("fl_hz_req", {127'd0, seen_stall}, 128'd0);
      check("fl_hz_bubble", {127'd0, bus.ex_valid}, 128'd0);
      cycle(mk(5'd9, 5'd7, 1'b1, 1'b0, 1'b0), "fl_after");
      check("fl_after_req", {127'd0, seen_stall}, 128'd0);

      // Asynchronous reset between edges while EX holds a valid writing instruction.
      cycle(mk(5'd6, 5'd1, 1'b1, 1'b0, 1'b0), "pre_rst");
      #2;
      rst_n = 1'b0;
      #1;
      ex_m = '0;
      m_stalls = 0;
      m_flushes = 0;
      check("arst_clear", {126'd0, bus.ex_valid, bus.ex_regwrite}, 128'd0);
      check_ex("arst");
      @(negedge clk);
      rst_n = 1'b1;
      cycle(mk(5'd8, 5'd2, 1'b1, 1'b0, 1'b0), "post_rst");
      check("post_rst_valid", {127'd0, bus.ex_valid}, 128'd1);

      // Randomized traffic with narrow register ranges so dependencies are frequent.
      for (int i = 0; i < 400; i++) begin
         rnd       = '0;
         rnd.valid = ($urandom_range(0, 4) != 0);
         rnd.rs1   = 5'($urandom_range(0, 3));
         rnd.rs2   = 5'($urandom_range(0, 3));
         rnd.rd    = 5'($urandom_range(0, 3));
         rnd.uses1 = 1'($urandom);
         rnd.uses2 = 1'($urandom);
         rnd.d1    = $urandom;
         rnd.d2    = $urandom;
         rnd.imm   = $urandom;
         rnd.pc    = $urandom;
         rnd.rw    = 1'($urandom);
         rnd.mr    = ($urandom_range(0, 2) == 0);
         rnd.mw    = 1'($urandom);
         rnd.mtr   = 1'($urandom);
         rnd.as    = 1'($urandom);
         rnd.op    = 4'($urandom);
         rnd.flush = ($urandom_range(0, 5) == 0);
         cycle(rnd, "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "bench timeout");
   end
endmodule
